turn_controller: RTL and testbench
==================================

Name: turn_controller

Overview:
- Front end of the chess clock. It produces the SELECT and STOP signals that drive the enable switch from player inputs and game state.
- Debounces the raw player and start/pause buttons. Runs the game-state FSM: idle, player 1 running, player 2 running, paused, game over. Counts moves.
- Turns flag-fall signals from the per-player countdown timers into a game-over condition and a winner indication.

Parameters:
- DEBOUNCE_TICKS, 8: number of consecutive CE ticks a synchronized button level must hold before the debounced level changes. Legal range 2..255.
- MOVE_W, 8: width of the move counter.

Ports:
- CLK  in  1  system clock
- CLR_N  in  1  asynchronous active-low reset
- CE  in  1  one-cycle debounce sampling tick (1 kHz in system)
- BTN_P1  in  1  raw player-1 button, async; player 1 presses to end own turn
- BTN_P2  in  1  raw player-2 button, async
- BTN_START  in  1  raw start/pause/new-game button, async
- FLAG_P1  in  1  player-1 time expired; level, synchronous to CLK
- FLAG_P2  in  1  player-2 time expired; level, synchronous to CLK
- SELECT  out  1  0 = player 1 side, 1 = player 2 side
- STOP  out  1  1 = both clocks halted
- WINNER  out  2  00 none, 01 player 1, 10 player 2
- LOAD  out  1  one-cycle pulse requesting timer reload for a new game
- MOVE_CNT  out  MOVE_W  completed turn switches, saturating

Behaviour:
- Reset (CLR_N low, asynchronous, takes effect immediately, including mid-game):
  - FSM = IDLE, SELECT=0, STOP=1, WINNER=00, LOAD=0, MOVE_CNT=0.
  - All synchronizers, debounce counters and debounced levels = 0.
- Input path, per button:
  - 2-FF synchronizer.
  - Debounce counter: on each CE cycle, if the synchronized level differs from the debounced level, increment; otherwise clear. When the counter reaches DEBOUNCE_TICKS, the debounced level takes the synchronized level and the counter clears.
  - Press pulse: one CLK cycle, on the 0->1 transition of the debounced level. Releases generate nothing.
  - Holding a button yields exactly one press.
- FSM is registered. SELECT, STOP and WINNER are decoded from registered state and change on the edge that changes state.
- IDLE (STOP=1, SELECT=0): START press -> RUN_P1 and LOAD pulses in the same cycle as the transition. All other inputs are ignored.
- RUN_P1 (STOP=0, SELECT=0). Evaluate in priority order:
  - FLAG_P1=1 -> OVER, WINNER=10.
  - Else START press -> PAUSE, saving side=0.
  - Else P1 press -> RUN_P2 and MOVE_CNT+1.
  - P2 presses and FLAG_P2 are ignored.
- RUN_P2: symmetric to RUN_P1 (SELECT=1; FLAG_P2 -> WINNER=01; P2 press -> RUN_P1 and MOVE_CNT+1).
- PAUSE (STOP=1, SELECT holds the saved side): START press -> the RUN state of the saved side. Player presses and flags are ignored.
- OVER (STOP=1, SELECT frozen, WINNER held): START press -> IDLE. WINNER=00, MOVE_CNT=0 and LOAD pulses on that edge. Player presses and flags are ignored.
- MOVE_CNT saturates at 2^MOVE_W-1 and does not wrap.
- Simultaneous events:
  - Flag beats button in the same cycle.
  - Both flags high in a RUN state: only the running side's flag counts.
  - P1 and P2 presses in the same cycle in RUN_P1: P1 wins and the turn switches once.
- CE low: debounce counters hold. The FSM still reacts to flags.

Test Plan:
- Reset mid-RUN_P2 with MOVE_CNT=5 -> SELECT=0, STOP=1, MOVE_CNT=0, WINNER=00, no LOAD pulse.
- DEBOUNCE_TICKS=4; BTN_START bounces 0/1 every CE for 3 ticks, then holds 1 for 4 CE ticks -> exactly one press pulse. IDLE->RUN_P1, STOP 1->0, one LOAD pulse.
- In RUN_P1, press P2 (ignored), then P1 -> SELECT 0->1, MOVE_CNT 0->1. Hold P1 for 50 CE ticks -> no further change.
- In RUN_P2, START -> STOP=1, SELECT=1. Pulse FLAG_P2 while paused -> no effect. START -> RUN_P2, STOP=0.
- In RUN_P1, assert FLAG_P1 and a P1 press in the same cycle -> OVER, WINNER=10, SELECT stays 0, MOVE_CNT unchanged. START -> IDLE, WINNER=00, LOAD pulse.
- MOVE_W=2: perform 5 turn switches -> MOVE_CNT sequence 1,2,3,3,3.

Source files
------------

// File: rtl/turn_controller.sv
// Chess-clock front end: debounces player/start buttons, runs the game-state FSM,
// counts moves and converts timer flag-fall into a winner indication.
module turn_controller #(
  parameter int DEBOUNCE_TICKS = 8,
  parameter int MOVE_W         = 8
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              CE,
  input  logic              BTN_P1,
  input  logic              BTN_P2,
  input  logic              BTN_START,
  input  logic              FLAG_P1,
  input  logic              FLAG_P2,
  output logic              SELECT,
  output logic              STOP,
  output logic [1:0]        WINNER,
  output logic              LOAD,
  output logic [MOVE_W-1:0] MOVE_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN_P1, ST_RUN_P2, ST_PAUSE, ST_OVER
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(DEBOUNCE_TICKS - 1);

  function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
    return (&v) ? v : v + MOVE_W'(1);
  endfunction

  // Bit order for all button vectors: [0] start, [1] player 1, [2] player 2.
  logic [2:0]      btn_raw;
  logic [2:0]      sync_p0, sync_p1;
  logic [2:0]      deb_lvl, deb_lvl_q;
  logic [2:0][7:0] deb_cnt;
  logic [2:0]      press;

  assign btn_raw = {BTN_P2, BTN_P1, BTN_START};

  // Synchronizer and debounce stage
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      deb_lvl   <= '0;
      deb_lvl_q <= '0;
      deb_cnt   <= '0;
    end else begin
      sync_p0   <= btn_raw;
      sync_p1   <= sync_p0;
      deb_lvl_q <= deb_lvl;
      if (CE) begin
        for (int i = 0; i < 3; i++) begin
          if (sync_p1[i] != deb_lvl[i]) begin
            if (deb_cnt[i] == TICK_LAST) begin
              deb_lvl[i] <= sync_p1[i];
              deb_cnt[i] <= '0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + 8'd1;
            end
          end else begin
            deb_cnt[i] <= '0;
          end
        end
      end
    end
  end

  assign press = deb_lvl & ~deb_lvl_q;

  state_t            state_q, state_nx;
  logic              side_q, side_nx;
  logic [1:0]        winner_q, winner_nx;
  logic [MOVE_W-1:0] move_q, move_nx;
  logic              load_q, load_nx;

  // Game state registers
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= ST_IDLE;
      side_q   <= 1'b0;
      winner_q <= 2'b00;
      move_q   <= '0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_nx;
      side_q   <= side_nx;
      winner_q <= winner_nx;
      move_q   <= move_nx;
      load_q   <= load_nx;
    end
  end

  // Flag is checked before any button so a flag-fall always ends the game.
  always_comb begin
    state_nx  = state_q;
    side_nx   = side_q;
    winner_nx = winner_q;
    move_nx   = move_q;
    load_nx   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press[0]) begin
          state_nx = ST_RUN_P1;
          side_nx  = 1'b0;
          load_nx  = 1'b1;
        end
      end
      ST_RUN_P1: begin
        if (FLAG_P1) begin
          state_nx  = ST_OVER;
          winner_nx = 2'b10;
        end else if (press[0]) begin
          state_nx = ST_PAUSE;
        end else if (press[1]) begin
          state_nx = ST_RUN_P2;
          side_nx  = 1'b1;
          move_nx  = sat_inc(move_q);
        end
      end
      ST_RUN_P2: begin
        if (FLAG_P2) begin
          state_nx  = ST_OVER;
          winner_nx = 2'b01;
        end else if (press[0]) begin
          state_nx = ST_PAUSE;
        end else if (press[2]) begin
          state_nx = ST_RUN_P1;
          side_nx  = 1'b0;
          move_nx  = sat_inc(move_q);
        end
      end
      ST_PAUSE: begin
        if (press[0]) state_nx = side_q ? ST_RUN_P2 : ST_RUN_P1;
      end
      ST_OVER: begin
        if (press[0]) begin
          state_nx  = ST_IDLE;
          side_nx   = 1'b0;
          winner_nx = 2'b00;
          move_nx   = '0;
          load_nx   = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    STOP     = !((state_q == ST_RUN_P1) || (state_q == ST_RUN_P2));
    SELECT   = side_q;
    WINNER   = winner_q;
    LOAD     = load_q;
    MOVE_CNT = move_q;
  end

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: a rule-level game model checked every cycle against two
// instances (8-bit and 2-bit move counters), plus directed scenarios with literal checks.
module tb_turn_controller;

  localparam int TICKS = 4;

  logic CLK = 1'b0, CLR_N = 1'b1, CE = 1'b0;
  logic BTN_P1 = 1'b0, BTN_P2 = 1'b0, BTN_START = 1'b0;
  logic FLAG_P1 = 1'b0, FLAG_P2 = 1'b0;
  logic       SELECT, STOP, LOAD;
  logic [1:0] WINNER;
  logic [7:0] MOVE_CNT;
  logic       SELECT2, STOP2, LOAD2;
  logic [1:0] WINNER2;
  logic [1:0] MOVE_CNT2;

  turn_controller #(.DEBOUNCE_TICKS(TICKS), .MOVE_W(8)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .BTN_P1(BTN_P1), .BTN_P2(BTN_P2),
    .BTN_START(BTN_START), .FLAG_P1(FLAG_P1), .FLAG_P2(FLAG_P2),
    .SELECT(SELECT), .STOP(STOP), .WINNER(WINNER), .LOAD(LOAD), .MOVE_CNT(MOVE_CNT));

  turn_controller #(.DEBOUNCE_TICKS(TICKS), .MOVE_W(2)) dut_w2 (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .BTN_P1(BTN_P1), .BTN_P2(BTN_P2),
    .BTN_START(BTN_START), .FLAG_P1(FLAG_P1), .FLAG_P2(FLAG_P2),
    .SELECT(SELECT2), .STOP(STOP2), .WINNER(WINNER2), .LOAD(LOAD2), .MOVE_CNT(MOVE_CNT2));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int load_seen = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model: mode, who runs, who won, total turn switches (unbounded).
  localparam int M_IDLE = 0, M_RUN1 = 1, M_RUN2 = 2, M_PAUSE = 3, M_OVER = 4;
  int mode = M_IDLE, m_side = 0, m_won = 0, mv = 0;
  bit m_load = 1'b0;
  bit [2:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_prev = '0, pr;
  int run [3] = '{0, 0, 0};
  logic [2:0] m_pend;
  assign m_pend = m_deb & ~m_prev;

  always @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      mode = M_IDLE; m_side = 0; m_won = 0; mv = 0; m_load = 1'b0;
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
      for (int i = 0; i < 3; i++) run[i] = 0;
    end else begin
      pr = m_deb & ~m_prev;
      m_load = 1'b0;
      case (mode)
        M_IDLE:  if (pr[0]) begin mode = M_RUN1; m_side = 0; m_load = 1'b1; end
        M_RUN1:  if (FLAG_P1) begin mode = M_OVER; m_won = 2; end
                 else if (pr[0]) mode = M_PAUSE;
                 else if (pr[1]) begin mode = M_RUN2; m_side = 1; mv++; end
        M_RUN2:  if (FLAG_P2) begin mode = M_OVER; m_won = 1; end
                 else if (pr[0]) mode = M_PAUSE;
                 else if (pr[2]) begin mode = M_RUN1; m_side = 0; mv++; end
        M_PAUSE: if (pr[0]) mode = (m_side == 1) ? M_RUN2 : M_RUN1;
        default: if (pr[0]) begin mode = M_IDLE; m_side = 0; m_won = 0; mv = 0; m_load = 1'b1; end
      endcase
      m_prev = m_deb;
      if (CE) begin
        for (int i = 0; i < 3; i++) begin
          if (m_s2[i] != m_deb[i]) begin
            run[i]++;
            if (run[i] == TICKS) begin m_deb[i] = m_s2[i]; run[i] = 0; end
          end else run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {BTN_P2, BTN_P1, BTN_START};
    end
  end

  always @(negedge CLK) begin
    if (LOAD) load_seen++;
    if (chk_en) begin
      check("model_stop",   STOP,      (mode == M_RUN1 || mode == M_RUN2) ? 0 : 1);
      check("model_select", SELECT,    m_side);
      check("model_winner", WINNER,    m_won);
      check("model_load",   LOAD,      m_load);
      check("model_move",   MOVE_CNT,  (mv > 255) ? 255 : mv);
      check("model_move_w2", MOVE_CNT2, (mv > 3) ? 3 : mv);
      check("model_stop_w2", STOP2,    STOP);
      check("model_sel_w2",  SELECT2,  m_side);
      check("model_win_w2",  WINNER2,  m_won);
      check("model_load_w2", LOAD2,    m_load);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      cyc++;
      CE = (cyc % 4 == 0);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: BTN_START = v;
      1: BTN_P1 = v;
      default: BTN_P2 = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1); step(32);
    set_btn(b, 1'b0); step(32);
  endtask

  int seq2 [5] = '{1, 2, 3, 3, 3};
  bit found;

  initial begin
    #1 CLR_N = 1'b0; chk_en = 1'b1;
    step(3);
    check("rst_stop", STOP, 1); check("rst_select", SELECT, 0);
    check("rst_winner", WINNER, 0); check("rst_load", LOAD, 0); check("rst_move", MOVE_CNT, 0);
    CLR_N = 1'b1; step(4);

    // Bouncing start button then a steady hold: one press, one LOAD.
    load_seen = 0;
    for (int i = 0; i < 3; i++) begin BTN_START = (i % 2 == 0); step(4); end
    BTN_START = 1'b1; step(24);
    check("bounce_load", load_seen, 1); check("bounce_stop", STOP, 0); check("bounce_sel", SELECT, 0);
    BTN_START = 1'b0; step(32);
    check("release_noload", load_seen, 1);

    // RUN_P1: P2 ignored, P1 switches; long hold gives one switch.
    press(2);
    check("p2_ignored_sel", SELECT, 0); check("p2_ignored_move", MOVE_CNT, 0);
    BTN_P1 = 1'b1; step(200);
    check("hold_sel", SELECT, 1); check("hold_move", MOVE_CNT, 1); check("hold_stop", STOP, 0);
    BTN_P1 = 1'b0; step(32);

    // Pause from RUN_P2, flag while paused is ignored, resume.
    press(0);
    check("pause_stop", STOP, 1); check("pause_sel", SELECT, 1);
    FLAG_P2 = 1'b1; step(1); FLAG_P2 = 1'b0; step(4);
    check("pause_flag_stop", STOP, 1); check("pause_flag_win", WINNER, 0);
    press(0);
    check("resume_stop", STOP, 0); check("resume_sel", SELECT, 1);

    // Flag and P1 press in the same cycle: flag wins.
    press(2);
    check("back_p1_sel", SELECT, 0); check("back_p1_move", MOVE_CNT, 2);
    BTN_P1 = 1'b1; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin step(1); if (m_pend[1]) found = 1'b1; end
    check("press_seen", found, 1);
    FLAG_P1 = 1'b1; step(1); FLAG_P1 = 1'b0;
    check("over_win", WINNER, 2); check("over_sel", SELECT, 0);
    check("over_move", MOVE_CNT, 2); check("over_stop", STOP, 1);
    BTN_P1 = 1'b0; step(32);
    load_seen = 0;
    press(0);
    check("newgame_win", WINNER, 0); check("newgame_move", MOVE_CNT, 0);
    check("newgame_stop", STOP, 1); check("newgame_load", load_seen, 1);

    // Five switches: 2-bit counter saturates; then reset mid-RUN_P2.
    press(0);
    for (int k = 0; k < 5; k++) begin
      press((k % 2 == 0) ? 1 : 2);
      check("move8", MOVE_CNT, k + 1);
      check("move2_sat", MOVE_CNT2, seq2[k]);
    end
    check("pre_rst_sel", SELECT, 1);
    load_seen = 0;
    step(1); #2 CLR_N = 1'b0; #1;
    check("midrst_sel", SELECT, 0); check("midrst_stop", STOP, 1);
    check("midrst_move", MOVE_CNT, 0); check("midrst_win", WINNER, 0);
    check("midrst_load", LOAD, 0); check("midrst_move2", MOVE_CNT2, 0);
    step(3); CLR_N = 1'b1; step(3);
    check("midrst_noload", load_seen, 0);

    // Simultaneous P1+P2 in RUN_P1 switches once; both flags in RUN_P2: P2's flag counts.
    press(0);
    BTN_P1 = 1'b1; BTN_P2 = 1'b1; step(32);
    BTN_P1 = 1'b0; BTN_P2 = 1'b0; step(32);
    check("both_btn_sel", SELECT, 1); check("both_btn_move", MOVE_CNT, 1);
    FLAG_P1 = 1'b1; FLAG_P2 = 1'b1; step(2);
    check("both_flag_win", WINNER, 1); check("both_flag_stop", STOP, 1); check("both_flag_sel", SELECT, 1);
    FLAG_P1 = 1'b0; FLAG_P2 = 1'b0;
    press(0);
    check("final_idle_stop", STOP, 1); check("final_idle_win", WINNER, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
